pipe_ctrl_gen: RTL and testbench

- Parametrised pipeline hazard/exception controller for the MIPS core; the successor to the 6-stage combinational stall/flush controller.
- Takes per-stage stall requests and the MEM-stage exception code. Drives the per-stage stall vector, a registered multi-cycle flush, and the redirect PC.
- Adds:
  - an EBASE-relative vector table;
  - a flush-hold FSM;
  - a stall watchdog;
  - a stall-cycle performance counter.

---
 rtl/pipe_ctrl_gen_pkg.sv | 41 ++++
 rtl/pipe_ctrl_gen_stall_decode.sv | 20 ++
 rtl/pipe_ctrl_gen.sv | 119 +++++++++++
 tb/tb_pipe_ctrl_gen.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_gen_pkg.sv
// Shared constants, FSM encoding and vector helper
// for the pipeline hazard/exception controller.
package pipe_ctrl_gen_pkg;

    localparam logic [31:0] EXC_NONE = 32'h0;
    localparam logic [31:0] EXC_INT  = 32'h1;
    localparam logic [31:0] EXC_SYS  = 32'h8;
    localparam logic [31:0] EXC_RI   = 32'ha;
    localparam logic [31:0] EXC_OV   = 32'hc;
    localparam logic [31:0] EXC_TR   = 32'hd;
    localparam logic [31:0] EXC_ERET = 32'he;

    localparam int STG_PC  = 0;
    localparam int STG_IF  = 1;
    localparam int STG_ID  = 2;
    localparam int STG_EX  = 3;
    localparam int STG_MEM = 4;
    localparam int STG_WB  = 5;

    typedef enum logic {
        ST_RUN,
        ST_FLUSH
    } state_t;

    function automatic logic [31:0] exc_target(
        input logic [31:0] code,
        input logic [31:0] epc,
        input logic [31:0] ebase,
        input logic [31:0] vint,
        input logic [31:0] vgen
    );
        logic [31:0] t;
        unique case (1'b1)
            code == EXC_ERET: t = epc;
            code == EXC_INT:  t = ebase + vint;
            default:          t = ebase + vgen;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/pipe_ctrl_gen_stall_decode.sv
// Stall request to stall mask: every stage at or
// below the highest requesting stage is held.
module pipe_ctrl_gen_stall_decode #(
    parameter int NSTAGE = 6
) (
    input  logic [NSTAGE-1:0] req,
    output logic [NSTAGE-1:0] mask
);

    always_comb begin
        logic acc;
        acc  = 1'b0;
        mask = '0;
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            acc     = acc | req[k];
            mask[k] = acc;
        end
    end

endmodule

// File: rtl/pipe_ctrl_gen.sv
// Pipeline hazard/exception controller: stall mask,
// multi-cycle flush with redirect, watchdog, stall counter.
module pipe_ctrl_gen
    import pipe_ctrl_gen_pkg::*;
#(
    parameter int          NSTAGE        = 6,
    parameter int          FLUSH_CYC     = 1,
    parameter logic [31:0] VEC_INT       = 32'h20,
    parameter logic [31:0] VEC_GEN       = 32'h40,
    parameter int          STALL_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NSTAGE-1:0] stallreq_i,
    input  logic [31:0]       excepttype_i,
    input  logic [31:0]       cp0_epc_i,
    input  logic [31:0]       ebase_i,
    output logic [NSTAGE-1:0] stall,
    output logic              flush,
    output logic [31:0]       new_pc,
    output logic              stall_timeout,
    output logic [31:0]       stall_cycles
);

    localparam logic [31:0] WD_LIM = 32'(STALL_TIMEOUT);
    localparam logic [3:0]  FC_LD  = 4'(FLUSH_CYC - 1);

    state_t            state, state_nx;
    logic [3:0]        fcnt, fcnt_nx;
    logic              flush_nx;
    logic [31:0]       pc_nx;
    logic [31:0]       wd_cnt, wd_nx;
    logic              to_nx;
    logic [NSTAGE-1:0] req_mask;
    logic              stall_any;
    logic              exc_take;

    pipe_ctrl_gen_stall_decode #(
        .NSTAGE(NSTAGE)
    ) u_dec (
        .req  (stallreq_i),
        .mask (req_mask)
    );

    // Gated by rst too so the mask drops the instant reset asserts.
    assign stall     = (rst && state == ST_RUN) ? req_mask : '0;
    assign stall_any = |stall;
    assign exc_take  = (state == ST_RUN) && (excepttype_i != EXC_NONE);

    always_comb begin
        state_nx = state;
        fcnt_nx  = fcnt;
        flush_nx = flush;
        pc_nx    = new_pc;
        unique case (state)
            ST_RUN: begin
                if (exc_take) begin
                    state_nx = ST_FLUSH;
                    fcnt_nx  = FC_LD;
                    flush_nx = 1'b1;
                    pc_nx    = exc_target(excepttype_i, cp0_epc_i,
                                          ebase_i, VEC_INT, VEC_GEN);
                end
            end
            ST_FLUSH: begin
                if (fcnt == 4'd0) begin
                    state_nx = ST_RUN;
                    flush_nx = 1'b0;
                    pc_nx    = '0;
                end else begin
                    fcnt_nx = fcnt - 4'd1;
                end
            end
            default: begin
                state_nx = ST_RUN;
                flush_nx = 1'b0;
                pc_nx    = '0;
            end
        endcase
    end

    // Count saturates at the limit so only one pulse fires per stall run.
    always_comb begin
        wd_nx = wd_cnt;
        to_nx = 1'b0;
        if (!stall_any || exc_take) begin
            wd_nx = '0;
        end else if (wd_cnt != WD_LIM) begin
            wd_nx = wd_cnt + 32'd1;
        end
        if (STALL_TIMEOUT != 0 && stall_any &&
            wd_cnt == WD_LIM - 32'd1) begin
            to_nx = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_RUN;
            fcnt          <= '0;
            flush         <= 1'b0;
            new_pc        <= '0;
            wd_cnt        <= '0;
            stall_timeout <= 1'b0;
            stall_cycles  <= '0;
        end else begin
            state         <= state_nx;
            fcnt          <= fcnt_nx;
            flush         <= flush_nx;
            new_pc        <= pc_nx;
            wd_cnt        <= wd_nx;
            stall_timeout <= to_nx;
            if (stall_any) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl_gen.sv
// Directed scoreboard bench for pipe_ctrl_gen using two
// instances (FLUSH_CYC=1/timeout 4 and FLUSH_CYC=3/no watchdog).
module tb_pipe_ctrl_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  sr;
    logic [31:0] exc, epc, eb;

    logic [5:0]  s1, s3;
    logic        f1, f3, to1, to3;
    logic [31:0] pc1, pc3, cy1, cy3;

    always #5 clk = ~clk;

    pipe_ctrl_gen #(
        .NSTAGE(6), .FLUSH_CYC(1), .STALL_TIMEOUT(4)
    ) u_dut1 (
        .clk(clk), .rst(rst), .stallreq_i(sr),
        .excepttype_i(exc), .cp0_epc_i(epc), .ebase_i(eb),
        .stall(s1), .flush(f1), .new_pc(pc1),
        .stall_timeout(to1), .stall_cycles(cy1)
    );

    pipe_ctrl_gen #(
        .NSTAGE(6), .FLUSH_CYC(3), .STALL_TIMEOUT(0)
    ) u_dut3 (
        .clk(clk), .rst(rst), .stallreq_i(sr),
        .excepttype_i(exc), .cp0_epc_i(epc), .ebase_i(eb),
        .stall(s3), .flush(f3), .new_pc(pc3),
        .stall_timeout(to3), .stall_cycles(cy3)
    );

    typedef struct {
        int          dut;
        int          kind;
        string       tag;
        logic [5:0]  st;
        logic        fl;
        logic [31:0] pc;
        logic        to;
        logic [31:0] cy;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic cmp(string tag, logic [31:0] obs, logic [31:0] ex);
        checks++;
        assert (obs === ex) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, ex);
        end
    endtask

    task automatic push(int d, string tag, logic [5:0] st,
                        logic fl, logic [31:0] pc, logic to);
        exp_t e;
        e.dut = d; e.kind = 0; e.tag = tag;
        e.st = st; e.fl = fl; e.pc = pc; e.to = to; e.cy = '0;
        sb.push_back(e);
    endtask

    task automatic push2(string tag, logic [5:0] st,
                         logic fl, logic [31:0] pc, logic to);
        push(1, tag, st, fl, pc, to);
        push(3, tag, st, fl, pc, to);
    endtask

    task automatic push_cy(int d, string tag, logic [31:0] cy);
        exp_t e;
        e.dut = d; e.kind = 1; e.tag = tag;
        e.st = '0; e.fl = 1'b0; e.pc = '0; e.to = 1'b0; e.cy = cy;
        sb.push_back(e);
    endtask

    task automatic check_all();
        exp_t e;
        string n;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n = $sformatf("%s.u%0d", e.tag, e.dut);
            if (e.kind == 1) begin
                cmp({n, ".cycles"}, (e.dut == 1) ? cy1 : cy3, e.cy);
            end else begin
                cmp({n, ".stall"}, {26'd0, (e.dut == 1) ? s1 : s3},
                    {26'd0, e.st});
                cmp({n, ".flush"}, {31'd0, (e.dut == 1) ? f1 : f3},
                    {31'd0, e.fl});
                cmp({n, ".pc"}, (e.dut == 1) ? pc1 : pc3, e.pc);
                cmp({n, ".tmo"}, {31'd0, (e.dut == 1) ? to1 : to3},
                    {31'd0, e.to});
            end
        end
    endtask

    task automatic cyc(logic [5:0] r, logic [31:0] x,
                       logic [31:0] p, logic [31:0] b);
        @(posedge clk);
        #1;
        sr = r; exc = x; epc = p; eb = b;
    endtask

    task automatic sample();
        #2;
        check_all();
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not end");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        sr = '0; exc = '0; epc = '0; eb = '0;
        #1 rst = 1'b0;
        #2;
        push2("reset", 6'd0, 1'b0, 32'd0, 1'b0);
        push_cy(1, "reset", 32'd0);
        push_cy(3, "reset", 32'd0);
        check_all();
        @(posedge clk);
        #3 rst = 1'b1;

        for (int i = 0; i < 3; i++) begin
            cyc(6'b001000, 32'h0, 32'h0, 32'h0);
            push2("t1_ex", 6'b001111, 1'b0, 32'h0, 1'b0);
            sample();
        end
        cyc(6'b0, 32'h0, 32'h0, 32'h0);
        push2("t1_idle", 6'b0, 1'b0, 32'h0, 1'b0);
        push_cy(1, "t1", 32'd3);
        push_cy(3, "t1", 32'd3);
        sample();

        cyc(6'b0, 32'h1, 32'h0, 32'hbfc00000);
        push2("t2_exc", 6'b0, 1'b0, 32'h0, 1'b0);
        sample();
        cyc(6'b0, 32'h0, 32'h0, 32'hbfc00000);
        push2("t2_fl", 6'b0, 1'b1, 32'hbfc00020, 1'b0);
        sample();
        cyc(6'b0, 32'h0, 32'h0, 32'hbfc00000);
        push(1, "t2_end", 6'b0, 1'b0, 32'h0, 1'b0);
        push(3, "t2_hold", 6'b0, 1'b1, 32'hbfc00020, 1'b0);
        sample();
        cyc(6'b0, 32'h0, 32'h0, 32'hbfc00000);
        push(1, "t2_idle", 6'b0, 1'b0, 32'h0, 1'b0);
        push(3, "t2_hold", 6'b0, 1'b1, 32'hbfc00020, 1'b0);
        sample();
        cyc(6'b0, 32'h0, 32'h0, 32'h0);
        push2("t2_done", 6'b0, 1'b0, 32'h0, 1'b0);
        sample();

        cyc(6'b000100, 32'he, 32'h00400104, 32'h0);
        push2("t3_same", 6'b000111, 1'b0, 32'h0, 1'b0);
        sample();
        cyc(6'b000100, 32'h0, 32'h00400104, 32'h0);
        push2("t3_fl", 6'b0, 1'b1, 32'h00400104, 1'b0);
        sample();
        for (int i = 0; i < 2; i++) begin
            cyc(6'b000100, 32'h0, 32'h00400104, 32'h0);
            push(1, "t3_run", 6'b000111, 1'b0, 32'h0, 1'b0);
            push(3, "t3_fl", 6'b0, 1'b1, 32'h00400104, 1'b0);
            sample();
        end
        cyc(6'b000100, 32'h0, 32'h00400104, 32'h0);
        push2("t3_resume", 6'b000111, 1'b0, 32'h0, 1'b0);
        sample();
        cyc(6'b0, 32'h0, 32'h0, 32'h0);
        push2("t3_idle", 6'b0, 1'b0, 32'h0, 1'b0);
        push_cy(1, "t3", 32'd7);
        push_cy(3, "t3", 32'd5);
        sample();

        cyc(6'b0, 32'h7, 32'h0, 32'h0);
        push2("t4_exc", 6'b0, 1'b0, 32'h0, 1'b0);
        sample();
        cyc(6'b0, 32'h0, 32'h0, 32'h0);
        push2("t4_gen", 6'b0, 1'b1, 32'h40, 1'b0);
        sample();
        cyc(6'b0, 32'h8, 32'h0, 32'hffffffe0);
        push(1, "t4_run", 6'b0, 1'b0, 32'h0, 1'b0);
        push(3, "t4_hold", 6'b0, 1'b1, 32'h40, 1'b0);
        sample();
        cyc(6'b0, 32'h0, 32'h0, 32'hffffffe0);
        push(1, "t4_wrap", 6'b0, 1'b1, 32'h20, 1'b0);
        push(3, "t4_hold", 6'b0, 1'b1, 32'h40, 1'b0);
        sample();
        cyc(6'b0, 32'h0, 32'h0, 32'h0);
        push2("t4_idle", 6'b0, 1'b0, 32'h0, 1'b0);
        sample();

        for (int i = 1; i <= 10; i++) begin
            cyc(6'b000010, 32'h0, 32'h0, 32'h0);
            push(1, $sformatf("t5_wd%0d", i), 6'b000011, 1'b0,
                 32'h0, (i == 5));
            push(3, $sformatf("t5_nowd%0d", i), 6'b000011, 1'b0,
                 32'h0, 1'b0);
            sample();
        end
        cyc(6'b0, 32'h0, 32'h0, 32'h0);
        push2("t5_gap", 6'b0, 1'b0, 32'h0, 1'b0);
        sample();
        for (int i = 1; i <= 5; i++) begin
            cyc(6'b000010, 32'h0, 32'h0, 32'h0);
            push(1, $sformatf("t5_re%0d", i), 6'b000011, 1'b0,
                 32'h0, (i == 5));
            push(3, $sformatf("t5_renowd%0d", i), 6'b000011, 1'b0,
                 32'h0, 1'b0);
            sample();
        end
        cyc(6'b0, 32'h0, 32'h0, 32'h0);
        push2("t5_idle", 6'b0, 1'b0, 32'h0, 1'b0);
        push_cy(1, "t5", 32'd22);
        push_cy(3, "t5", 32'd20);
        sample();

        cyc(6'b0, 32'hd, 32'h0, 32'h0);
        push2("t6_exc", 6'b0, 1'b0, 32'h0, 1'b0);
        sample();
        cyc(6'b0, 32'h0, 32'h0, 32'h0);
        push2("t6_fl1", 6'b0, 1'b1, 32'h40, 1'b0);
        sample();
        cyc(6'b0, 32'h0, 32'h0, 32'h0);
        push(1, "t6_d1", 6'b0, 1'b0, 32'h0, 1'b0);
        push(3, "t6_fl2", 6'b0, 1'b1, 32'h40, 1'b0);
        sample();
        #1;
        rst = 1'b0;
        sr  = 6'b001000;
        #1;
        push2("t6_rst", 6'b0, 1'b0, 32'h0, 1'b0);
        push_cy(1, "t6_rst", 32'd0);
        push_cy(3, "t6_rst", 32'd0);
        check_all();
        @(posedge clk);
        #1;
        push2("t6_held", 6'b0, 1'b0, 32'h0, 1'b0);
        check_all();
        #2;
        sr  = 6'b0;
        rst = 1'b1;

        cyc(6'b0, 32'h0, 32'h0, 32'h0);
        push2("t6_idle", 6'b0, 1'b0, 32'h0, 1'b0);
        sample();
        cyc(6'b000001, 32'h0, 32'h0, 32'h0);
        push2("b_pc", 6'b000001, 1'b0, 32'h0, 1'b0);
        sample();
        cyc(6'b100000, 32'h0, 32'h0, 32'h0);
        push2("b_wb", 6'b111111, 1'b0, 32'h0, 1'b0);
        sample();
        cyc(6'b101010, 32'h0, 32'h0, 32'h0);
        push2("b_multi", 6'b111111, 1'b0, 32'h0, 1'b0);
        sample();
        cyc(6'b0, 32'h0, 32'h0, 32'h0);
        push2("b_idle", 6'b0, 1'b0, 32'h0, 1'b0);
        sample();
        cyc(6'b000110, 32'h0, 32'h0, 32'h0);
        push2("b_id_if", 6'b000111, 1'b0, 32'h0, 1'b0);
        sample();
        cyc(6'b0, 32'h0, 32'h0, 32'h0);
        push2("b_end", 6'b0, 1'b0, 32'h0, 1'b0);
        push_cy(1, "b_end", 32'd4);
        push_cy(3, "b_end", 32'd4);
        sample();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
